// File: rtl/ysyx_25040109_axi_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
// State encoding, response codes, and the request-vector bit order used by the priority pick.
package ysyx_25040109_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_M0 = 3'd1,
    ST_RD_M1 = 3'd2,
    ST_WR_M0 = 3'd3,
    ST_WR_M1 = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Lower index wins.
  localparam int PRIO_M1_WR = 0;
  localparam int PRIO_M1_RD = 1;
  localparam int PRIO_M0_WR = 2;
  localparam int PRIO_M0_RD = 3;
  localparam int N_REQ      = 4;

endpackage

// File: rtl/ysyx_25040109_axi_arbiter.sv
// Fixed-priority 2:1 AXI4-Lite arbiter (IFU=m0, LSU=m1), one transaction in flight.
// Grant one cycle after the request is seen in IDLE; data/response paths are combinational; losers wait.
module ysyx_25040109_axi_arbiter
  import ysyx_25040109_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  output logic [1:0]          m0_bresp,

  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,

  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp
);

  state_t             r_state;
  state_t             w_next;
  logic               r_ar_done;
  logic               r_aw_done;
  logic               r_w_done;
  logic [N_REQ-1:0]   w_req;
  logic               w_rd0, w_rd1, w_wr0, w_wr1;
  logic               w_r_hs, w_b_hs;

  function automatic state_t pick(input logic [N_REQ-1:0] req);
    state_t grant;
    grant = ST_IDLE;
    if (req[PRIO_M1_WR])      grant = ST_WR_M1;
    else if (req[PRIO_M1_RD]) grant = ST_RD_M1;
    else if (req[PRIO_M0_WR]) grant = ST_WR_M0;
    else if (req[PRIO_M0_RD]) grant = ST_RD_M0;
    return grant;
  endfunction

  always_comb begin
    w_req             = '0;
    w_req[PRIO_M1_WR] = m1_awvalid | m1_wvalid;
    w_req[PRIO_M1_RD] = m1_arvalid;
    w_req[PRIO_M0_WR] = m0_awvalid | m0_wvalid;
    w_req[PRIO_M0_RD] = m0_arvalid;
  end

  assign w_rd0 = (r_state == ST_RD_M0);
  assign w_rd1 = (r_state == ST_RD_M1);
  assign w_wr0 = (r_state == ST_WR_M0);
  assign w_wr1 = (r_state == ST_WR_M1);

  assign w_r_hs = s_rvalid & s_rready;
  assign w_b_hs = s_bvalid & s_bready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:            w_next = pick(w_req);
      ST_RD_M0, ST_RD_M1: if (w_r_hs) w_next = ST_IDLE;
      ST_WR_M0, ST_WR_M1: if (w_b_hs) w_next = ST_IDLE;
      default:            w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Done flags keep each address/data beat to exactly one handshake per grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_r_hs)   r_ar_done <= 1'b0;
      else if (s_arvalid && s_arready)    r_ar_done <= 1'b1;

      if (r_state == ST_IDLE || w_b_hs) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (s_awvalid && s_awready) r_aw_done <= 1'b1;
        if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
      end
    end
  end

  assign s_arvalid = ((w_rd0 & m0_arvalid) | (w_rd1 & m1_arvalid)) & ~r_ar_done;
  assign s_araddr  = w_rd0 ? m0_araddr : (w_rd1 ? m1_araddr : '0);
  assign s_rready  = (w_rd0 & m0_rready) | (w_rd1 & m1_rready);

  assign s_awvalid = ((w_wr0 & m0_awvalid) | (w_wr1 & m1_awvalid)) & ~r_aw_done;
  assign s_awaddr  = w_wr0 ? m0_awaddr : (w_wr1 ? m1_awaddr : '0);
  assign s_wvalid  = ((w_wr0 & m0_wvalid) | (w_wr1 & m1_wvalid)) & ~r_w_done;
  assign s_wdata   = w_wr0 ? m0_wdata : (w_wr1 ? m1_wdata : '0);
  assign s_wstrb   = w_wr0 ? m0_wstrb : (w_wr1 ? m1_wstrb : '0);
  assign s_bready  = (w_wr0 & m0_bready) | (w_wr1 & m1_bready);

  assign m0_arready = w_rd0 & s_arready & ~r_ar_done;
  assign m0_rvalid  = w_rd0 & s_rvalid;
  assign m0_rdata   = w_rd0 ? s_rdata : '0;
  assign m0_rresp   = w_rd0 ? s_rresp : '0;
  assign m0_awready = w_wr0 & s_awready & ~r_aw_done;
  assign m0_wready  = w_wr0 & s_wready & ~r_w_done;
  assign m0_bvalid  = w_wr0 & s_bvalid;
  assign m0_bresp   = w_wr0 ? s_bresp : '0;

  assign m1_arready = w_rd1 & s_arready & ~r_ar_done;
  assign m1_rvalid  = w_rd1 & s_rvalid;
  assign m1_rdata   = w_rd1 ? s_rdata : '0;
  assign m1_rresp   = w_rd1 ? s_rresp : '0;
  assign m1_awready = w_wr1 & s_awready & ~r_aw_done;
  assign m1_wready  = w_wr1 & s_wready & ~r_w_done;
  assign m1_bvalid  = w_wr1 & s_bvalid;
  assign m1_bresp   = w_wr1 ? s_bresp : '0;

endmodule

// File: tb/tb_ysyx_25040109_axi_arbiter.sv
// Directed bench for the two-master AXI4-Lite arbiter; expectations are hand-computed per cycle.
module tb_ysyx_25040109_axi_arbiter;
  import ysyx_25040109_axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk, rst;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
  logic m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic [ADDR_W-1:0] m0_araddr, m0_awaddr;
  logic [DATA_W-1:0] m0_rdata, m0_wdata;
  logic [DATA_W/8-1:0] m0_wstrb;
  logic [1:0] m0_rresp, m0_bresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
  logic m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [ADDR_W-1:0] m1_araddr, m1_awaddr;
  logic [DATA_W-1:0] m1_rdata, m1_wdata;
  logic [DATA_W/8-1:0] m1_wstrb;
  logic [1:0] m1_rresp, m1_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready;
  logic [ADDR_W-1:0] s_araddr, s_awaddr;
  logic [DATA_W-1:0] s_rdata, s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic [1:0] s_rresp, s_bresp;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_25040109_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [40:0] m1_outs();
    return {m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_awready, m1_wready, m1_bvalid, m1_bresp};
  endfunction

  function automatic logic [40:0] m0_outs();
    return {m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_awready, m0_wready, m0_bvalid, m0_bresp};
  endfunction

  logic [31:0] rd_addr [3];
  logic [31:0] rd_data [3];

  initial begin
    rd_addr[0] = 32'h8000_0100; rd_addr[1] = 32'h8000_0104; rd_addr[2] = 32'h8000_0108;
    rd_data[0] = 32'h1111_0001; rd_data[1] = 32'h2222_0002; rd_data[2] = 32'h3333_0003;

    rst = 1'b1;
    {m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready} = '0;
    {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
    m0_araddr = '0; m0_awaddr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_araddr = '0; m1_awaddr = '0; m1_wdata = '0; m1_wstrb = '0;
    {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_bresp = RESP_OKAY;

    // Reset held two cycles while m0 requests
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; s_arready = 1'b1;
    tick(); tick(); #1;
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_m0_arready", 64'(m0_arready), 64'd0);
    chk("rst_s_araddr", 64'(s_araddr), 64'd0);
    rst = 1'b0; #1;
    chk("rel_s_arvalid", 64'(s_arvalid), 64'd0);

    // m0 read, AR accepted immediately, R after two wait cycles
    tick(); #1;
    chk("rd0_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("rd0_s_araddr", 64'(s_araddr), 64'h8000_0000);
    chk("rd0_m0_arready", 64'(m0_arready), 64'd1);
    chk("rd0_m1_quiet_a", 64'(m1_outs()), 64'd0);
    tick(); m0_arvalid = 1'b0; s_arready = 1'b0; #1;
    chk("rd0_ar_once", 64'(s_arvalid), 64'd0);
    chk("rd0_wait_rvalid", 64'(m0_rvalid), 64'd0);
    tick(); #1;
    chk("rd0_m1_quiet_b", 64'(m1_outs()), 64'd0);
    tick(); s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rresp = RESP_OKAY; m0_rready = 1'b1; #1;
    chk("rd0_m0_rvalid", 64'(m0_rvalid), 64'd1);
    chk("rd0_m0_rdata", 64'(m0_rdata), 64'h0000_0413);
    chk("rd0_m0_rresp", 64'(m0_rresp), 64'(RESP_OKAY));
    chk("rd0_s_rready", 64'(s_rready), 64'd1);
    chk("rd0_m1_quiet_c", 64'(m1_outs()), 64'd0);
    tick(); #1;
    chk("rd0_idle_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rd0_idle_rready", 64'(s_rready), 64'd0);
    s_rvalid = 1'b0; m0_rready = 1'b0;

    // m0 read and m1 write arrive together: m1 write goes first
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0004;
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_1000;
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_bready = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1;
    tick(); #1;
    chk("pri_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("pri_s_awaddr", 64'(s_awaddr), 64'h8000_1000);
    chk("pri_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    chk("pri_s_wstrb", 64'(s_wstrb), 64'hF);
    chk("pri_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("pri_m1_aw_w_rdy", 64'({m1_awready, m1_wready}), 64'b11);
    chk("pri_m0_quiet", 64'(m0_outs()), 64'd0);
    tick(); m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = RESP_OKAY; #1;
    chk("pri_m1_bvalid", 64'(m1_bvalid), 64'd1);
    chk("pri_m0_bvalid", 64'(m0_bvalid), 64'd0);
    tick(); s_bvalid = 1'b0; m1_bready = 1'b0; #1;
    chk("pri_idle_arvalid", 64'(s_arvalid), 64'd0);
    tick(); s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678; m0_rready = 1'b1; #1;
    chk("pri_rd_s_arvalid", 64'(s_arvalid), 64'd1);
    chk("pri_rd_s_araddr", 64'(s_araddr), 64'h8000_0004);
    chk("pri_rd_m0_rdata", 64'(m0_rdata), 64'h1234_5678);
    tick(); m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b0; #1;
    chk("pri_rd_done", 64'(s_arvalid), 64'd0);

    // m1 write: W accepted two cycles before AW, SLVERR forwarded
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_2000;
    m1_wvalid = 1'b1; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'h3; m1_bready = 1'b1;
    s_wready = 1'b1;
    tick(); #1;
    chk("wfirst_s_wvalid", 64'(s_wvalid), 64'd1);
    chk("wfirst_m1_wready", 64'(m1_wready), 64'd1);
    chk("wfirst_m1_awready", 64'(m1_awready), 64'd0);
    tick(); #1;
    chk("wfirst_w_once", 64'(s_wvalid), 64'd0);
    chk("wfirst_wready_lo", 64'(m1_wready), 64'd0);
    chk("wfirst_aw_held", 64'(s_awvalid), 64'd1);
    tick(); s_awready = 1'b1; #1;
    chk("wfirst_w_still_lo", 64'(s_wvalid), 64'd0);
    chk("wfirst_m1_awready2", 64'(m1_awready), 64'd1);
    tick(); m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = RESP_SLVERR; #1;
    chk("wfirst_aw_once", 64'(s_awvalid), 64'd0);
    chk("wfirst_m1_bresp", 64'(m1_bresp), 64'(RESP_SLVERR));
    chk("wfirst_m0_bresp", 64'(m0_bresp), 64'd0);
    tick(); s_bvalid = 1'b0; s_bresp = RESP_OKAY; m1_bready = 1'b0; #1;
    chk("wfirst_idle_bvalid", 64'(m1_bvalid), 64'd0);

    // m0 holding both write and read: write first, read after the next IDLE
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_3000;
    m0_awvalid = 1'b1; m0_awaddr = 32'h8000_3004; m0_wvalid = 1'b1; m0_wdata = 32'h0BAD_F00D;
    m0_wstrb = 4'hC; m0_bready = 1'b1;
    tick(); s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = RESP_DECERR; #1;
    chk("m0wr_s_awvalid", 64'(s_awvalid), 64'd1);
    chk("m0wr_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("m0wr_s_wstrb", 64'(s_wstrb), 64'hC);
    chk("m0wr_m0_bresp", 64'(m0_bresp), 64'(RESP_DECERR));
    tick(); m0_awvalid = 1'b0; m0_wvalid = 1'b0; m0_bready = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; #1;
    chk("m0wr_idle", 64'({s_awvalid, s_arvalid}), 64'd0);
    tick(); s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hA5A5_0000; s_rresp = RESP_OKAY;
    m0_rready = 1'b1; #1;
    chk("m0rd_s_araddr", 64'(s_araddr), 64'h8000_3000);
    chk("m0rd_m0_rdata", 64'(m0_rdata), 64'hA5A5_0000);
    tick(); m0_arvalid = 1'b0; m0_rready = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; #1;

    // m1 back-to-back reads, zero-wait slave: IDLE, AR, R repeating
    m1_arvalid = 1'b1; m1_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m1_araddr = rd_addr[i];
      tick(); s_arready = 1'b1; #1;
      chk($sformatf("b2b%0d_araddr", i), 64'(s_araddr), 64'(rd_addr[i]));
      chk($sformatf("b2b%0d_arready", i), 64'(m1_arready), 64'd1);
      tick(); s_rvalid = 1'b1; s_rdata = rd_data[i]; #1;
      chk($sformatf("b2b%0d_ar_once", i), 64'(s_arvalid), 64'd0);
      chk($sformatf("b2b%0d_rdata", i), 64'({m1_rvalid, m1_rdata}), {31'd0, 1'b1, rd_data[i]});
      tick(); s_rvalid = 1'b0; s_arready = 1'b0; #1;
      chk($sformatf("b2b%0d_idle", i), 64'({s_arvalid, m1_rvalid}), 64'd0);
    end
    m1_arvalid = 1'b0; m1_rready = 1'b0;
    tick();

    // Reset in the middle of RD_M1 before R arrives
    m1_arvalid = 1'b1; m1_araddr = 32'h9000_0000;
    tick(); #1;
    chk("abort_pre_arvalid", 64'(s_arvalid), 64'd1);
    s_arready = 1'b1; rst = 1'b1; #1;
    chk("abort_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("abort_m1_arready", 64'(m1_arready), 64'd0);
    chk("abort_s_araddr", 64'(s_araddr), 64'd0);
    tick(); rst = 1'b0; #1;
    chk("abort_rel_quiet", 64'({s_arvalid, m1_outs()}), 64'd0);
    tick(); s_rvalid = 1'b1; s_rdata = 32'h55AA_55AA; s_rresp = RESP_SLVERR; m1_rready = 1'b1; #1;
    chk("abort_again_araddr", 64'(s_araddr), 64'h9000_0000);
    chk("abort_again_arready", 64'(m1_arready), 64'd1);
    chk("abort_again_rdata", 64'(m1_rdata), 64'h55AA_55AA);
    chk("abort_again_rresp", 64'(m1_rresp), 64'(RESP_SLVERR));
    tick(); m1_arvalid = 1'b0; m1_rready = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; #1;
    chk("abort_again_idle", 64'({s_arvalid, s_rready}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
